matrix_alloc_arbiter: RTL

MATRIX_ALLOC_ARBITER -- requirements
Module: matrix_alloc_arbiter

---
 rtl/matrix_alloc_arbiter.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/matrix_alloc_arbiter.sv
// Slot allocator for matrix BRAM regions: round-robin grants, owner-checked commits, registered lookup.
// Optional MATRIX_ALLOC_OVERWRITE_EN: evict a VALID slot instead of refusing when no slot is FREE.
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 11
`endif

module matrix_alloc_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_SLOTS  = 8,
  parameter int ADDR_WIDTH = `BRAM_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_alloc,
  input  logic [NUM_REQ-1:0]      req_commit,
  input  logic [4*NUM_REQ-1:0]    commit_slot_in,
  input  logic [5*NUM_REQ-1:0]    commit_m_in,
  input  logic [5*NUM_REQ-1:0]    commit_n_in,
  output logic [NUM_REQ-1:0]      grant_valid,
  output logic [3:0]              grant_slot,
  output logic [ADDR_WIDTH-1:0]   grant_addr,
  output logic [NUM_REQ-1:0]      alloc_err,
  output logic [NUM_REQ-1:0]      commit_ack,
  output logic [NUM_REQ-1:0]      commit_err,
  input  logic [3:0]              qry_slot,
  output logic                    qry_valid,
  output logic [4:0]              qry_m,
  output logic [4:0]              qry_n,
  output logic [ADDR_WIDTH-1:0]   qry_addr,
  output logic [3:0]              slot_count,
  output logic                    full
);

  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [4:0] SLOT_LIMIT = 5'(NUM_SLOTS);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SEARCH = 3'd1;
  localparam logic [2:0] ST_GRANT  = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;

  localparam logic [1:0] SL_FREE  = 2'd0;
  localparam logic [1:0] SL_PEND  = 2'd1;
  localparam logic [1:0] SL_VALID = 2'd2;

  logic [2:0]    state;
  logic [RW-1:0] rr_ptr;
  logic [RW-1:0] winner;
  logic [3:0]    sel_slot;
  logic          sel_ok;

  logic [1:0]    slot_state [NUM_SLOTS];
  logic [4:0]    slot_m     [NUM_SLOTS];
  logic [4:0]    slot_n     [NUM_SLOTS];
  logic [RW-1:0] slot_owner [NUM_SLOTS];

  logic [NUM_REQ-1:0] pend;
  logic [3:0]    pend_slot [NUM_REQ];
  logic [4:0]    pend_m    [NUM_REQ];
  logic [4:0]    pend_n    [NUM_REQ];

`ifdef MATRIX_ALLOC_OVERWRITE_EN
  logic [SW-1:0] victim_ptr;
  logic          vic_hi_found, vic_lo_found;
  logic [SW-1:0] vic_hi, vic_lo;
`endif

  function automatic logic [ADDR_WIDTH-1:0] base_of(input logic [3:0] s);
    return ADDR_WIDTH'({s, 8'h00});
  endfunction

  // Round-robin: first requester at or above the pointer, else wrap to the lowest.
  logic          rr_hi_found, rr_lo_found;
  logic [RW-1:0] rr_hi, rr_lo, rr_win;

  always_comb begin
    rr_hi_found = 1'b0;
    rr_lo_found = 1'b0;
    rr_hi = '0;
    rr_lo = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rr_hi_found && req_alloc[i] && (RW'(i) >= rr_ptr)) begin
        rr_hi_found = 1'b1;
        rr_hi = RW'(i);
      end
      if (!rr_lo_found && req_alloc[i]) begin
        rr_lo_found = 1'b1;
        rr_lo = RW'(i);
      end
    end
    rr_win = rr_hi_found ? rr_hi : rr_lo;
  end

  logic       free_found;
  logic [3:0] free_idx;
  logic [3:0] valid_cnt;

  always_comb begin
    free_found = 1'b0;
    free_idx = '0;
    valid_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!free_found && slot_state[i] == SL_FREE) begin
        free_found = 1'b1;
        free_idx = 4'(i);
      end
      if (slot_state[i] == SL_VALID) valid_cnt = valid_cnt + 4'd1;
    end
  end

`ifdef MATRIX_ALLOC_OVERWRITE_EN
  // Victim scan starts at the victim pointer and never selects a PENDING slot.
  always_comb begin
    vic_hi_found = 1'b0;
    vic_lo_found = 1'b0;
    vic_hi = '0;
    vic_lo = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!vic_hi_found && slot_state[i] == SL_VALID && (SW'(i) >= victim_ptr)) begin
        vic_hi_found = 1'b1;
        vic_hi = SW'(i);
      end
      if (!vic_lo_found && slot_state[i] == SL_VALID) begin
        vic_lo_found = 1'b1;
        vic_lo = SW'(i);
      end
    end
  end
`endif

  logic               cm_found;
  logic [RW-1:0]      cm_idx;
  logic [NUM_REQ-1:0] cm_onehot;
  logic [3:0]         cm_slot;
  logic [SW-1:0]      cm_sidx;
  logic [4:0]         cm_m, cm_n;
  logic               cm_ok;
  logic [NUM_REQ-1:0] pend_clr;

  always_comb begin
    cm_found = 1'b0;
    cm_idx = '0;
    cm_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!cm_found && pend[i]) begin
        cm_found = 1'b1;
        cm_idx = RW'(i);
        cm_onehot[i] = 1'b1;
      end
    end
    cm_slot = pend_slot[cm_idx];
    cm_m = pend_m[cm_idx];
    cm_n = pend_n[cm_idx];
    cm_sidx = cm_slot[SW-1:0];
    cm_ok = ({1'b0, cm_slot} < SLOT_LIMIT) && (slot_state[cm_sidx] == SL_PEND) &&
            (slot_owner[cm_sidx] == cm_idx) && (cm_m != 5'd0) && (cm_m <= 5'd16) &&
            (cm_n != 5'd0) && (cm_n <= 5'd16);
    pend_clr = (state == ST_COMMIT) ? cm_onehot : '0;
  end

  logic [SW-1:0] sel_sidx;
  logic [SW-1:0] q_sidx;
  logic          q_hit;
  logic          any_free;

  always_comb begin
    sel_sidx = sel_slot[SW-1:0];
    q_sidx = qry_slot[SW-1:0];
    q_hit = ({1'b0, qry_slot} < SLOT_LIMIT) && (slot_state[q_sidx] == SL_VALID);
    any_free = free_found;
  end

  // Commit payloads only matter while their pend bit is set, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_commit[i]) begin
        pend_slot[i] <= commit_slot_in[4*i +: 4];
        pend_m[i] <= commit_m_in[5*i +: 5];
        pend_n[i] <= commit_n_in[5*i +: 5];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      rr_ptr <= '0;
      winner <= '0;
      sel_slot <= '0;
      sel_ok <= 1'b0;
      pend <= '0;
      grant_valid <= '0;
      grant_slot <= '0;
      grant_addr <= '0;
      alloc_err <= '0;
      commit_ack <= '0;
      commit_err <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_state[i] <= SL_FREE;
        slot_m[i] <= '0;
        slot_n[i] <= '0;
        slot_owner[i] <= '0;
      end
`ifdef MATRIX_ALLOC_OVERWRITE_EN
      victim_ptr <= '0;
`endif
    end else begin
      grant_valid <= '0;
      grant_slot <= '0;
      grant_addr <= '0;
      alloc_err <= '0;
      commit_ack <= '0;
      commit_err <= '0;
      pend <= (pend & ~pend_clr) | req_commit;
      case (state)
        ST_IDLE: begin
          if ((pend | req_commit) != '0) begin
            state <= ST_COMMIT;
          end else if (req_alloc != '0) begin
            winner <= rr_win;
            state <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
`ifdef MATRIX_ALLOC_OVERWRITE_EN
          if (free_found) begin
            sel_slot <= free_idx;
            sel_ok <= 1'b1;
          end else begin
            sel_slot <= 4'(vic_hi_found ? vic_hi : vic_lo);
            sel_ok <= vic_hi_found | vic_lo_found;
          end
`else
          sel_slot <= free_idx;
          sel_ok <= free_found;
`endif
          state <= ST_GRANT;
        end
        ST_GRANT: begin
          if (sel_ok) begin
            slot_state[sel_sidx] <= SL_PEND;
            slot_owner[sel_sidx] <= winner;
            grant_valid[winner] <= 1'b1;
            grant_slot <= sel_slot;
            grant_addr <= base_of(sel_slot);
`ifdef MATRIX_ALLOC_OVERWRITE_EN
            if (slot_state[sel_sidx] == SL_VALID)
              victim_ptr <= (sel_sidx == SW'(NUM_SLOTS-1)) ? '0 : sel_sidx + 1'b1;
`endif
          end else begin
            alloc_err[winner] <= 1'b1;
          end
          rr_ptr <= (winner == RW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
          state <= ST_HOLD;
        end
        ST_HOLD: state <= ST_IDLE;
        ST_COMMIT: begin
          if (cm_found) begin
            if (cm_ok) begin
              slot_state[cm_sidx] <= SL_VALID;
              slot_m[cm_sidx] <= cm_m;
              slot_n[cm_sidx] <= cm_n;
              commit_ack[cm_idx] <= 1'b1;
            end else begin
              commit_err[cm_idx] <= 1'b1;
            end
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Lookup and occupancy are registered views of the table as it stood before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      qry_valid <= 1'b0;
      qry_m <= '0;
      qry_n <= '0;
      qry_addr <= '0;
      slot_count <= '0;
      full <= 1'b0;
    end else begin
      qry_valid <= q_hit;
      qry_m <= q_hit ? slot_m[q_sidx] : 5'd0;
      qry_n <= q_hit ? slot_n[q_sidx] : 5'd0;
      qry_addr <= q_hit ? base_of(qry_slot) : '0;
      slot_count <= valid_cnt;
      full <= !any_free;
    end
  end

endmodule
